memory_port_arbiter: RTL and testbench

//   Shares the single data port of Memory between two requesters: the CPU load/store unit (cpu_*) and
//   the boot-loader/DMA engine (dma_*). Arbitrates round-robin per beat and supports locked bursts
//   (e.g. swl/swr pairs, block copies), with a bounded burst length under contention.

---
 rtl/memory_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - round-robin arbiter sharing Memory's data port between CPU and DMA
module memory_port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_lock,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic [2:0]  cpu_writeMode,
    input  logic [2:0]  cpu_readMode,
    input  logic        cpu_unsignedLoad,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_address,
    input  logic [31:0] dma_data,
    input  logic [2:0]  dma_writeMode,
    input  logic [2:0]  dma_readMode,
    input  logic        dma_unsignedLoad,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [31:0] dma_rdata,

    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_writeMode,
    output logic [2:0]  mem_readMode,
    output logic        mem_unsignedLoad,
    input  logic [31:0] mem_dataOutput
);

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam int         CW        = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_dma_q, last_dma_d;
    logic          cpu_done_q, dma_done_q;
    logic [31:0]   cpu_rdata_q, dma_rdata_q;

    logic          cpu_beat, dma_beat;
    logic          own_req, own_lock, other_req;

    assign cpu_gnt   = (state_q == OWN_CPU) && !rst;
    assign dma_gnt   = (state_q == OWN_DMA) && !rst;
    assign cpu_done  = cpu_done_q;
    assign dma_done  = dma_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

    assign cpu_beat = cpu_gnt && cpu_req;
    assign dma_beat = dma_gnt && dma_req;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_dma_d = last_dma_q;
        own_req    = 1'b0;
        own_lock   = 1'b0;
        other_req  = 1'b0;

        if (dma_beat) begin
            last_dma_d = 1'b1;
        end else if (cpu_beat) begin
            last_dma_d = 1'b0;
        end

        case (state_q)
            OWN_CPU: begin
                own_req   = cpu_req;
                own_lock  = cpu_lock;
                other_req = dma_req;
            end
            OWN_DMA: begin
                own_req   = dma_req;
                own_lock  = dma_lock;
                other_req = cpu_req;
            end
            default: ;
        endcase

        if (state_q == IDLE) begin
            count_d = '0;
            // On a tie the requester that did not own the port last wins.
            if (cpu_req && (!dma_req || last_dma_q)) begin
                state_d = OWN_CPU;
                count_d = CNT_ONE;
            end else if (dma_req) begin
                state_d = OWN_DMA;
                count_d = CNT_ONE;
            end
        end else begin
            // Lock only holds the port while the burst is short or nobody else is waiting.
            if (own_lock && own_req && (!other_req || (count_q < CNT_MAX))) begin
                count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
            end else if (other_req) begin
                state_d = (state_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
                count_d = CNT_ONE;
            end else if (own_req) begin
                count_d = CNT_ONE;
            end else begin
                state_d = IDLE;
                count_d = '0;
            end
        end
    end

    // Memory sees nothing while idle or in reset, so an in-flight write is dropped.
    always_comb begin
        mem_address      = 32'd0;
        mem_data         = 32'd0;
        mem_writeMode    = MODE_NONE;
        mem_readMode     = MODE_NONE;
        mem_unsignedLoad = 1'b0;
        if (cpu_gnt) begin
            mem_address      = cpu_address;
            mem_data         = cpu_data;
            mem_unsignedLoad = cpu_unsignedLoad;
            if (cpu_req) begin
                mem_writeMode = cpu_writeMode;
                mem_readMode  = cpu_readMode;
            end
        end else if (dma_gnt) begin
            mem_address      = dma_address;
            mem_data         = dma_data;
            mem_unsignedLoad = dma_unsignedLoad;
            if (dma_req) begin
                mem_writeMode = dma_writeMode;
                mem_readMode  = dma_readMode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            last_dma_q  <= 1'b1;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_dma_q <= last_dma_d;
            cpu_done_q <= cpu_beat;
            dma_done_q <= dma_beat;
            if (cpu_beat && (cpu_readMode != MODE_NONE)) begin
                cpu_rdata_q <= mem_dataOutput;
            end
            if (dma_beat && (dma_readMode != MODE_NONE)) begin
                dma_rdata_q <= mem_dataOutput;
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed bench for memory_port_arbiter with a small Memory model
module tb_memory_port_arbiter;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_BYTE = 3'd1;
    localparam logic [2:0] M_WORD = 3'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_lock, cpu_unsignedLoad;
    logic [31:0] cpu_address, cpu_data;
    logic [2:0]  cpu_writeMode, cpu_readMode;
    logic        cpu_gnt, cpu_done;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_lock, dma_unsignedLoad;
    logic [31:0] dma_address, dma_data;
    logic [2:0]  dma_writeMode, dma_readMode;
    logic        dma_gnt, dma_done;
    logic [31:0] dma_rdata;
    logic [31:0] mem_address, mem_data, mem_dataOutput;
    logic [2:0]  mem_writeMode, mem_readMode;
    logic        mem_unsignedLoad;

    int errors = 0;
    int checks = 0;

    memory_port_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_writeMode(cpu_writeMode), .cpu_readMode(cpu_readMode), .cpu_unsignedLoad(cpu_unsignedLoad),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_address(dma_address), .dma_data(dma_data),
        .dma_writeMode(dma_writeMode), .dma_readMode(dma_readMode), .dma_unsignedLoad(dma_unsignedLoad),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_writeMode(mem_writeMode),
        .mem_readMode(mem_readMode), .mem_unsignedLoad(mem_unsignedLoad), .mem_dataOutput(mem_dataOutput)
    );

    // Big-endian byte memory, combinational read, write committed at the rising edge.
    logic [7:0]  mem [0:65535];
    logic [15:0] ra, wa;

    always_comb begin
        ra = mem_address[15:0];
        wa = {mem_address[15:2], 2'b00};
        mem_dataOutput = 32'd0;
        case (mem_readMode)
            M_BYTE: mem_dataOutput = mem_unsignedLoad ? {24'd0, mem[ra]} : {{24{mem[ra][7]}}, mem[ra]};
            M_WORD: mem_dataOutput = {mem[wa], mem[wa | 16'd1], mem[wa | 16'd2], mem[wa | 16'd3]};
            default: ;
        endcase
    end

    task automatic put_word(input logic [15:0] a, input logic [31:0] d);
        mem[a]          = d[31:24];
        mem[a | 16'd1]  = d[23:16];
        mem[a | 16'd2]  = d[15:8];
        mem[a | 16'd3]  = d[7:0];
    endtask

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem[a], mem[a | 16'd1], mem[a | 16'd2], mem[a | 16'd3]};
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            put_word(16'(16'h0100 + 4 * i), 32'hC000_0000 + 32'(i));
            put_word(16'(16'h0200 + 4 * i), 32'hD000_0000 + 32'(i));
        end
        forever begin
            @(posedge clk);
            case (mem_writeMode)
                M_BYTE: mem[mem_address[15:0]] = mem_data[7:0];
                M_WORD: put_word({mem_address[15:2], 2'b00}, mem_data);
                default: ;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic rq, input logic lk, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic u);
        cpu_req = rq; cpu_lock = lk; cpu_address = a; cpu_data = d;
        cpu_writeMode = wm; cpu_readMode = rm; cpu_unsignedLoad = u;
    endtask

    task automatic set_dma(input logic rq, input logic lk, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic u);
        dma_req = rq; dma_lock = lk; dma_address = a; dma_data = d;
        dma_writeMode = wm; dma_readMode = rm; dma_unsignedLoad = u;
    endtask

    // One unlocked beat from IDLE by a single requester.
    task automatic single_op(input logic is_cpu, input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] wm, input logic [2:0] rm, input logic u,
                             input logic [31:0] exp_rd);
        if (is_cpu) set_cpu(1'b1, 1'b0, a, d, wm, rm, u);
        else        set_dma(1'b1, 1'b0, a, d, wm, rm, u);
        #1;
        check({tag, " gnt_at_req"}, is_cpu ? cpu_gnt : dma_gnt, 1'b0);
        tick;
        check({tag, " gnt"}, is_cpu ? cpu_gnt : dma_gnt, 1'b1);
        check({tag, " other_gnt"}, is_cpu ? dma_gnt : cpu_gnt, 1'b0);
        check({tag, " mem_address"}, mem_address, a);
        check({tag, " mem_data"}, mem_data, d);
        check({tag, " mem_writeMode"}, mem_writeMode, wm);
        check({tag, " mem_readMode"}, mem_readMode, rm);
        check({tag, " mem_unsignedLoad"}, mem_unsignedLoad, u);
        tick;
        check({tag, " done"}, is_cpu ? cpu_done : dma_done, 1'b1);
        if (rm != M_NONE) check({tag, " rdata"}, is_cpu ? cpu_rdata : dma_rdata, exp_rd);
        if (is_cpu) cpu_req = 1'b0;
        else        dma_req = 1'b0;
        tick;
        check({tag, " done_clear"}, is_cpu ? cpu_done : dma_done, 1'b0);
        check({tag, " gnt_clear"}, is_cpu ? cpu_gnt : dma_gnt, 1'b0);
    endtask

    int          cb, db;
    logic [31:0] exp_c, exp_d;
    logic [7:0]  order;

    initial begin
        rst = 1'b1;
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0, M_NONE, M_NONE, 1'b0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, M_NONE, M_NONE, 1'b0);
        tick;
        tick;
        check("rst cpu_gnt", cpu_gnt, 1'b0);
        check("rst dma_gnt", dma_gnt, 1'b0);
        check("rst cpu_done", cpu_done, 1'b0);
        check("rst dma_done", dma_done, 1'b0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        check("rst dma_rdata", dma_rdata, 32'd0);
        check("rst mem_writeMode", mem_writeMode, M_NONE);
        check("rst mem_address", mem_address, 32'd0);
        rst = 1'b0;

        // CPU alone: write then read back.
        single_op(1'b1, "t1 wr", 32'd65532, 32'h2234_5678, M_WORD, M_NONE, 1'b0, 32'd0);
        check("t1 mem_word", word_at(16'hFFFC), 32'h2234_5678);
        single_op(1'b1, "t1 rd", 32'd65532, 32'd0, M_NONE, M_WORD, 1'b0, 32'h2234_5678);

        // Both request right after reset: C,D,C,D,... with rdata routed to its owner.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cb = 0; db = 0; exp_c = 32'd0; exp_d = 32'd0;
        set_cpu(1'b1, 1'b0, 32'h100, 32'd0, M_NONE, M_WORD, 1'b0);
        set_dma(1'b1, 1'b0, 32'h200, 32'd0, M_NONE, M_WORD, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            tick;
            if (t >= 2) begin
                if (t % 2 == 0) begin
                    exp_c = 32'hC000_0000 + 32'(cb);
                    check("t2 cpu_done", cpu_done, 1'b1);
                    check("t2 dma_done_quiet", dma_done, 1'b0);
                    check("t2 cpu_rdata", cpu_rdata, exp_c);
                    check("t2 dma_rdata_hold", dma_rdata, exp_d);
                    cb++;
                    set_cpu(cb < 4, 1'b0, 32'h100 + 32'(4 * cb), 32'd0, M_NONE, M_WORD, 1'b0);
                end else begin
                    exp_d = 32'hD000_0000 + 32'(db);
                    check("t2 dma_done", dma_done, 1'b1);
                    check("t2 cpu_done_quiet", cpu_done, 1'b0);
                    check("t2 dma_rdata", dma_rdata, exp_d);
                    check("t2 cpu_rdata_hold", cpu_rdata, exp_c);
                    db++;
                    set_dma(db < 4, 1'b0, 32'h200 + 32'(4 * db), 32'd0, M_NONE, M_WORD, 1'b0);
                end
            end
            if (t <= 8) begin
                check("t2 cpu_gnt", cpu_gnt, (t % 2 == 1));
                check("t2 dma_gnt", dma_gnt, (t % 2 == 0));
            end
        end
        tick;

        // DMA locked 6-beat burst, CPU joins at beat 2: D,D,D,D,C,D,D.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        db = 0;
        order = 8'b0001_0000;
        set_dma(1'b1, 1'b1, 32'd65512, 32'hDA00_0000, M_WORD, M_NONE, 1'b0);
        for (int t = 1; t <= 8; t++) begin
            tick;
            if (t == 2) set_cpu(1'b1, 1'b0, 32'h100, 32'd0, M_NONE, M_WORD, 1'b0);
            if (t >= 2) begin
                if (order[t-2]) begin
                    check("t3 cpu_done", cpu_done, 1'b1);
                    check("t3 cpu_rdata", cpu_rdata, 32'hC000_0000);
                    set_cpu(1'b0, 1'b0, 32'd0, 32'd0, M_NONE, M_NONE, 1'b0);
                end else begin
                    check("t3 dma_done", dma_done, 1'b1);
                    db++;
                    set_dma(db < 6, db < 5, 32'd65512 + 32'(4 * db), 32'hDA00_0000 + 32'(db),
                            M_WORD, M_NONE, 1'b0);
                end
            end
            if (t <= 7) begin
                check("t3 cpu_gnt", cpu_gnt, order[t-1]);
                check("t3 dma_gnt", dma_gnt, !order[t-1]);
            end
        end
        tick;
        for (int i = 0; i < 6; i++) begin
            check("t3 burst_word", word_at(16'(16'hFFE8 + 4 * i)), 32'hDA00_0000 + 32'(i));
        end

        // Reset lands on a DMA write beat: the write is suppressed and no done follows.
        single_op(1'b0, "t5 pre", 32'h200, 32'd0, M_NONE, M_WORD, 1'b0, 32'hD000_0000);
        single_op(1'b0, "t5 clr", 32'd65528, 32'd0, M_WORD, M_NONE, 1'b0, 32'd0);
        check("t5 word_cleared", word_at(16'hFFF8), 32'd0);
        set_dma(1'b1, 1'b0, 32'd65528, 32'h1234_5678, M_WORD, M_NONE, 1'b0);
        tick;
        check("t5 dma_gnt_before", dma_gnt, 1'b1);
        rst = 1'b1;
        #1;
        check("t5 dma_gnt_in_rst", dma_gnt, 1'b0);
        check("t5 mem_writeMode_in_rst", mem_writeMode, M_NONE);
        check("t5 mem_address_in_rst", mem_address, 32'd0);
        check("t5 mem_data_in_rst", mem_data, 32'd0);
        tick;
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, M_NONE, M_NONE, 1'b0);
        check("t5 word_unchanged", word_at(16'hFFF8), 32'd0);
        check("t5 dma_done", dma_done, 1'b0);
        check("t5 dma_rdata", dma_rdata, 32'd0);
        check("t5 cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        tick;
        check("t5 dma_done_after", dma_done, 1'b0);
        check("t5 dma_gnt_after", dma_gnt, 1'b0);

        // Byte store and signed/unsigned byte loads.
        single_op(1'b0, "t4 wrD4", 32'd65528, 32'h0000_00D4, M_BYTE, M_NONE, 1'b0, 32'd0);
        single_op(1'b1, "t4 wrA1", 32'd65531, 32'h0000_00A1, M_BYTE, M_NONE, 1'b0, 32'd0);
        single_op(1'b1, "t4 rd_signed", 32'd65531, 32'd0, M_NONE, M_BYTE, 1'b0, 32'hFFFF_FFA1);
        single_op(1'b1, "t4 rd_unsigned", 32'd65531, 32'd0, M_NONE, M_BYTE, 1'b1, 32'h0000_00A1);
        single_op(1'b0, "t4 rd_D4", 32'd65528, 32'd0, M_NONE, M_BYTE, 1'b1, 32'h0000_00D4);

        // CPU drops req on its granted cycle; waiting DMA takes the next cycle.
        set_cpu(1'b1, 1'b0, 32'h300, 32'hBADB_AD00, M_WORD, M_NONE, 1'b0);
        tick;
        check("t6 cpu_gnt", cpu_gnt, 1'b1);
        set_cpu(1'b0, 1'b0, 32'h300, 32'hBADB_AD00, M_WORD, M_NONE, 1'b0);
        set_dma(1'b1, 1'b0, 32'h200, 32'd0, M_NONE, M_WORD, 1'b0);
        #1;
        check("t6 mem_writeMode", mem_writeMode, M_NONE);
        tick;
        check("t6 cpu_done", cpu_done, 1'b0);
        check("t6 dma_gnt", dma_gnt, 1'b1);
        check("t6 cpu_gnt_off", cpu_gnt, 1'b0);
        tick;
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, M_NONE, M_NONE, 1'b0);
        check("t6 dma_done", dma_done, 1'b1);
        check("t6 dma_rdata", dma_rdata, 32'hD000_0000);
        check("t6 cpu_done_late", cpu_done, 1'b0);
        check("t6 word_unchanged", word_at(16'h0300), 32'd0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
